// File: rtl/fpu_seq_pkg.sv
// Shared FPU definitions: opcode encoding, byte-bus register map and the
// sequencer state encoding used by fpu_seq.
package pa_fpu;

  typedef enum logic [7:0] {
    op_add  = 8'h00,
    op_sub  = 8'h01,
    op_mul  = 8'h02,
    op_div  = 8'h03,
    op_sqrt = 8'h04
  } e_fpu_operation;

  localparam logic [3:0] ADDR_A0 = 4'd0;
  localparam logic [3:0] ADDR_B0 = 4'd4;
  localparam logic [3:0] ADDR_OP = 4'd8;
  localparam logic [3:0] ADDR_R0 = 4'd9;

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    WAIT_END,
    RD_SETUP,
    RD_STROBE,
    RD_HOLD,
    ACK,
    RESP
  } e_fpu_seq_state;

  // Byte driven on the data bus for write index 0..8 (A, B LSB-first, then op).
  function automatic logic [7:0] wr_byte(input logic [3:0] idx, input logic [31:0] a,
                                         input logic [31:0] b, input logic [7:0] op);
    logic [7:0] r;
    if (idx < ADDR_B0)      r = 8'(a >> {idx[1:0], 3'b000});
    else if (idx < ADDR_OP) r = 8'(b >> {idx[1:0], 3'b000});
    else                    r = op;
    return r;
  endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// Round-robin arbiter: grants the first asserted request after ptr_i,
// wrapping around, so the last winner has lowest priority.
module fpu_rr_arb #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            any_o
);

  int c;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    c         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[c]) begin
        any_o       = 1'b1;
        gnt_oh_o[c] = 1'b1;
        gnt_idx_o   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/fpu_seq.sv
// Sequencer sharing one 8-bit memory-mapped FPU between NREQ requesters:
// writes A/B/op byte-wise, waits for cmd_end, reads the result, acks, responds.
module fpu_seq
  import pa_fpu::*;
#(
  parameter int NREQ        = 2,
  parameter int STROBE_CYC  = 1,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*8-1:0]  req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_err,
  output logic               fpu_cs,
  output logic               fpu_wr,
  output logic               fpu_rd,
  output logic [3:0]         fpu_addr,
  output logic [7:0]         fpu_din,
  input  logic [7:0]         fpu_dout,
  output logic               fpu_end_ack,
  input  logic               fpu_cmd_end,
  input  logic               fpu_busy,
  output e_fpu_seq_state     dbg_state
);

  // Handshake: a request is accepted in the cycle req_ready[g] pulses while
  // req_valid[g] is high; a response is consumed when rsp_valid && rsp_ready.
  localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  e_fpu_seq_state state_q;
  logic [3:0]      idx_q;
  logic [SW-1:0]   stb_q;
  logic [TW-1:0]   tmo_q;
  logic [IW-1:0]   ptr_q;
  logic [7:0]      op_q;
  logic [31:0]     a_q, b_q;
  logic [NREQ-1:0] req_ready_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [IW-1:0]   rsp_id_q;
  logic [31:0]     rsp_result_q;
  logic            cs_q, wr_q, rd_q, end_ack_q;
  logic [3:0]      addr_q;
  logic [7:0]      din_q;

  logic [NREQ-1:0] gnt_oh;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [7:0]      op_g;
  logic [31:0]     a_g, b_g;

  fpu_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign op_g = req_op[int'(gnt_idx)*8 +: 8];
  assign a_g  = req_a[int'(gnt_idx)*32 +: 32];
  assign b_g  = req_b[int'(gnt_idx)*32 +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      stb_q        <= '0;
      tmo_q        <= '0;
      ptr_q        <= IW'(NREQ - 1);
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      cs_q         <= 1'b1;
      wr_q         <= 1'b1;
      rd_q         <= 1'b1;
      end_ack_q    <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: if (gnt_any && !fpu_busy && !fpu_cmd_end) begin
          req_ready_q <= gnt_oh;
          ptr_q       <= gnt_idx;
          rsp_id_q    <= gnt_idx;
          op_q        <= op_g;
          a_q         <= a_g;
          b_q         <= b_g;
          rsp_err_q   <= 1'b0;
          idx_q       <= '0;
          cs_q        <= 1'b0;
          addr_q      <= ADDR_A0;
          din_q       <= a_g[7:0];
          state_q     <= WR_SETUP;
        end
        WR_SETUP: begin
          wr_q    <= 1'b0;
          stb_q   <= SW'(STROBE_CYC - 1);
          state_q <= WR_STROBE;
        end
        WR_STROBE: if (stb_q == '0) begin
          wr_q    <= 1'b1;
          state_q <= WR_HOLD;
        end else begin
          stb_q <= stb_q - 1'b1;
        end
        WR_HOLD: if (idx_q == ADDR_OP) begin
          cs_q    <= 1'b1;
          tmo_q   <= '0;
          state_q <= WAIT_END;
        end else begin
          idx_q   <= idx_q + 4'd1;
          addr_q  <= idx_q + 4'd1;
          din_q   <= wr_byte(idx_q + 4'd1, a_q, b_q, op_q);
          state_q <= WR_SETUP;
        end
        WAIT_END: if (fpu_cmd_end) begin
          idx_q   <= '0;
          cs_q    <= 1'b0;
          addr_q  <= ADDR_R0;
          state_q <= RD_SETUP;
        end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
          // Stalled FPU: report an error with a zero result, skip the read.
          rsp_err_q    <= 1'b1;
          rsp_result_q <= '0;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        RD_SETUP: begin
          rd_q    <= 1'b0;
          stb_q   <= SW'(STROBE_CYC - 1);
          state_q <= RD_STROBE;
        end
        RD_STROBE: if (stb_q == '0) begin
          rsp_result_q[{idx_q[1:0], 3'b000} +: 8] <= fpu_dout;
          rd_q    <= 1'b1;
          state_q <= RD_HOLD;
        end else begin
          stb_q <= stb_q - 1'b1;
        end
        RD_HOLD: if (idx_q == 4'd3) begin
          cs_q      <= 1'b1;
          end_ack_q <= 1'b1;
          tmo_q     <= '0;
          state_q   <= ACK;
        end else begin
          idx_q   <= idx_q + 4'd1;
          addr_q  <= addr_q + 4'd1;
          state_q <= RD_SETUP;
        end
        ACK: if (!fpu_cmd_end) begin
          end_ack_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
          end_ack_q   <= 1'b0;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_err     = rsp_err_q;
  assign fpu_cs      = cs_q;
  assign fpu_wr      = wr_q;
  assign fpu_rd      = rd_q;
  assign fpu_addr    = addr_q;
  assign fpu_din     = din_q;
  assign fpu_end_ack = end_ack_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq with a behavioural byte-bus FPU model and a
// bus monitor that logs write bytes, chip-select runs and strobe rules.
module tb_fpu_seq;
  import pa_fpu::*;

  localparam int NREQ = 2;
  localparam int STROBE = 1;
  localparam int TMO = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*8-1:0]   req_op;
  logic [NREQ*32-1:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [0:0]          rsp_id;
  logic [31:0]         rsp_result;
  logic                fpu_cs, fpu_wr, fpu_rd, fpu_end_ack, fpu_cmd_end, fpu_busy;
  logic [3:0]          fpu_addr;
  logic [7:0]          fpu_din, fpu_dout;
  e_fpu_seq_state      dbg_state;

  always #5 clk = ~clk;

  fpu_seq #(.NREQ(NREQ), .STROBE_CYC(STROBE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_cs(fpu_cs), .fpu_wr(fpu_wr), .fpu_rd(fpu_rd), .fpu_addr(fpu_addr),
    .fpu_din(fpu_din), .fpu_dout(fpu_dout), .fpu_end_ack(fpu_end_ack),
    .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy), .dbg_state(dbg_state)
  );

  typedef struct {
    int          rid;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vec[5];
  int   pend[NREQ];
  int   errors = 0;
  int   checks = 0;

  // ---------------- FPU model ----------------
  logic [7:0]  mregs[0:8];
  logic [31:0] mres;
  logic        m_busy, m_end, stall, busy_force;
  int          m_cnt;

  function automatic logic [31:0] lookup(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++)
      if (vec[i].op == op && vec[i].a == a && vec[i].b == b) r = vec[i].res;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_end  <= 1'b0;
      m_cnt  <= 0;
      mres   <= '0;
    end else begin
      if (!fpu_cs && !fpu_wr && fpu_addr <= 4'd8) mregs[fpu_addr] <= fpu_din;
      if (!fpu_cs && !fpu_wr && fpu_addr == 4'd8 && !m_busy && !m_end) begin
        m_busy <= 1'b1;
        m_cnt  <= 5;
      end else if (m_busy && !stall) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          m_end  <= 1'b1;
          mres   <= lookup(mregs[8], {mregs[3], mregs[2], mregs[1], mregs[0]},
                           {mregs[7], mregs[6], mregs[5], mregs[4]});
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (m_end && fpu_end_ack) m_end <= 1'b0;
    end
  end

  assign fpu_busy    = m_busy | busy_force;
  assign fpu_cmd_end = m_end;

  always_comb begin
    case (fpu_addr)
      4'd9:    fpu_dout = mres[7:0];
      4'd10:   fpu_dout = mres[15:8];
      4'd11:   fpu_dout = mres[23:16];
      4'd12:   fpu_dout = mres[31:24];
      default: fpu_dout = 8'h00;
    endcase
  end

  // ---------------- bus monitor ----------------
  logic [11:0] wlog[$];
  int          runs[$];
  int          viol = 0, rd_lows = 0, run_cs = 0, wr_run = 0, rd_run = 0;
  logic        prev_wr = 1'b1, prev_rd = 1'b1, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (!fpu_wr && !fpu_rd) viol++;
      if (fpu_cs && (!fpu_wr || !fpu_rd)) viol++;
      if (!fpu_wr) begin
        if (prev_wr) wlog.push_back({fpu_addr, fpu_din});
        wr_run++;
      end else if (!prev_wr) begin
        if (wr_run != STROBE) viol++;
        wr_run = 0;
      end
      if (!fpu_rd) begin
        rd_lows++;
        rd_run++;
      end else if (!prev_rd) begin
        if (rd_run != STROBE) viol++;
        rd_run = 0;
      end
      if (!fpu_cs) run_cs++;
      else if (!prev_cs) begin
        runs.push_back(run_cs);
        run_cs = 0;
      end
      prev_wr = fpu_wr;
      prev_rd = fpu_rd;
      prev_cs = fpu_cs;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_req(input int r, input int vi);
    req_op[r*8 +: 8]  = vec[vi].op;
    req_a[r*32 +: 32] = vec[vi].a;
    req_b[r*32 +: 32] = vec[vi].b;
    req_valid[r]      = 1'b1;
    pend[r]           = vi;
  endtask

  task automatic take_grant(input int r);
    req_valid[r] = 1'b0;
    wlog.delete();
    runs.delete();
    rd_lows = 0;
  endtask

  task automatic wait_grant(input int exp_r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 300);
    chk("grant", 32'(req_ready), 32'(1 << exp_r));
    take_grant(exp_r);
  endtask

  task automatic finish(input int vi, input int exp_r, input logic [31:0] exp_res,
                        input logic exp_err, input int hold, input bit full);
    int n, bad;
    logic [7:0] eb;
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_id", 32'(rsp_id), 32'(exp_r));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    if (full) begin
      chk("wr_count", 32'(wlog.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
        if (i < 4)      eb = 8'(vec[vi].a >> (8 * i));
        else if (i < 8) eb = 8'(vec[vi].b >> (8 * (i - 4)));
        else            eb = vec[vi].op;
        if (i < wlog.size()) chk("wr_byte", 32'(wlog[i]), {20'd0, 4'(i), eb});
      end
      chk("cs_runs", 32'(runs.size()), 32'd2);
      if (runs.size() >= 2) begin
        chk("wr_phase_cycles", 32'(runs[0]), 32'd27);
        chk("rd_phase_cycles", 32'(runs[1]), 32'd12);
      end
    end
    if (hold > 0) begin
      bad = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!(rsp_valid === 1'b1 && rsp_result === exp_res && rsp_id === 1'(exp_r) &&
              req_ready === '0)) bad++;
      end
      chk("rsp_hold_stable", 32'(bad), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cs"}, 32'(fpu_cs), 32'd1);
    chk({tag, "_wr"}, 32'(fpu_wr), 32'd1);
    chk({tag, "_rd"}, 32'(fpu_rd), 32'd1);
    chk({tag, "_end_ack"}, 32'(fpu_end_ack), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, c, bad;
    vec[0] = '{0, op_mul, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
    vec[1] = '{1, op_add, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    vec[2] = '{0, op_mul, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
    vec[3] = '{1, op_sub, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000};
    vec[4] = '{0, op_div, 32'h4080_0000, 32'h4000_0000, 32'h4000_0000};

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; stall = 1'b0; busy_force = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_addr", 32'(fpu_addr), 32'd0);
    chk("reset_din", 32'(fpu_din), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;

    // single requests from the vector table
    for (int v = 0; v < 5; v++) begin
      start_req(vec[v].rid, v);
      wait_grant(vec[v].rid);
      finish(v, vec[v].rid, vec[v].res, 1'b0, 0, 1'b1);
    end

    // both requesters valid after reset: order 0,1,0,1, first response held
    pulse_reset();
    start_req(0, 1);
    start_req(1, 2);
    wait_grant(0);
    finish(1, 0, 32'h4040_0000, 1'b0, 20, 1'b1);
    wait_grant(1);
    finish(2, 1, 32'h4080_0000, 1'b0, 0, 1'b1);
    start_req(0, 3);
    start_req(1, 4);
    wait_grant(0);
    finish(3, 0, vec[3].res, 1'b0, 0, 1'b1);
    wait_grant(1);
    finish(4, 1, vec[4].res, 1'b0, 0, 1'b1);

    // stalled FPU: timeout in WAIT_END
    stall = 1'b1;
    start_req(0, 0);
    wait_grant(0);
    n = 0;
    while (!fpu_cs && n < 200) begin
      @(negedge clk);
      n++;
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!rsp_valid && c < 300);
    chk("timeout_cycles", 32'(c), 32'(TMO + 1));
    chk("timeout_cs", 32'(fpu_cs), 32'd1);
    chk("timeout_rd_lows", 32'(rd_lows), 32'd0);
    chk("timeout_cs_runs", 32'(runs.size()), 32'd1);
    finish(0, 0, 32'd0, 1'b1, 0, 1'b0);
    stall = 1'b0;
    pulse_reset();

    // reset during the strobe of byte 5, request left pending
    start_req(0, 1);
    wait_grant(0);
    n = 0;
    while (!(fpu_wr == 1'b0 && fpu_addr == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("byte5_strobe_addr", 32'(fpu_addr), 32'd5);
    rst = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    wait_grant(0);
    finish(1, 0, 32'h4040_0000, 1'b0, 0, 1'b1);

    // fpu_busy blocks the grant in IDLE
    busy_force = 1'b1;
    start_req(1, 2);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready !== '0 || fpu_cs !== 1'b1) bad++;
    end
    chk("busy_block", 32'(bad), 32'd0);
    busy_force = 1'b0;
    @(negedge clk);
    chk("grant_after_busy", 32'(req_ready), 32'd2);
    take_grant(1);
    finish(2, 1, 32'h4080_0000, 1'b0, 0, 1'b1);

    chk("bus_protocol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
